// File: rtl/fp_mult_seq_pkg.sv
// Shared definitions for the sequential floating-point multiplier: FSM states,
// flag bit positions and binary32 field/classification helpers.
package fp_mult_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        UNPACK = 3'd1,
        MUL    = 3'd2,
        NORM   = 3'd3,
        DONE   = 3'd4
    } fsm_state_e;

    localparam int unsigned FLG_INVALID   = 32'd3;
    localparam int unsigned FLG_OVERFLOW  = 32'd2;
    localparam int unsigned FLG_UNDERFLOW = 32'd1;
    localparam int unsigned FLG_INEXACT   = 32'd0;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } float32_t;

    typedef enum logic [1:0] {
        FC_ZERO   = 2'd0,
        FC_NORMAL = 2'd1,
        FC_INF    = 2'd2,
        FC_NAN    = 2'd3
    } fp_class_e;

    // Denormals classify as zero because the multiplier flushes them.
    function automatic fp_class_e fp32_classify(input float32_t x);
        fp_class_e c;
        if (x.exp == 8'hFF) begin
            c = (x.frac == 23'd0) ? FC_INF : FC_NAN;
        end else if (x.exp == 8'h00) begin
            c = FC_ZERO;
        end else begin
            c = FC_NORMAL;
        end
        return c;
    endfunction

    function automatic logic fp32_is_nan(input float32_t x);
        return (fp32_classify(x) == FC_NAN);
    endfunction

endpackage

// File: rtl/fp_round_norm.sv
// Combinational normalise / round-to-nearest-even / range check for the
// 2M-bit significand product. Flag outputs exist only with FP_FLAGS_EN.
module fp_round_norm
    import fp_mult_seq_pkg::*;
#(
    parameter int EXP_BITS  = 8,
    parameter int FRAC_BITS = 23,
    localparam int W = 1 + EXP_BITS + FRAC_BITS,
    localparam int M = FRAC_BITS + 1
) (
    input  logic [2*M-1:0]            prod,
    input  logic                      sign,
    input  logic signed [EXP_BITS+1:0] exp,
    output logic [W-1:0]              result
`ifdef FP_FLAGS_EN
    ,
    output logic                      overflow,
    output logic                      underflow,
    output logic                      inexact
`endif
);

    localparam int EW = EXP_BITS + 2;
    localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);
    localparam logic signed [EW-1:0] EXP_ZERO = EW'(0);
    localparam logic signed [EW-1:0] EXP_MAX  = EW'((2 ** EXP_BITS) - 1);

    logic [M-1:0]           sig_s;
    logic                   guard_s;
    logic                   sticky_s;
    logic                   round_up_s;
    logic [M:0]             sum_s;
    logic signed [EW-1:0]   exp_adj_s;
    logic signed [EW-1:0]   exp_fin_s;
    logic [FRAC_BITS-1:0]   frac_fin_s;
    logic                   ovf_s;
    logic                   unf_s;

    // Pick the M-bit window, round it, and range-check the final exponent.
    always_comb begin
        sig_s      = '0;
        guard_s    = 1'b0;
        sticky_s   = 1'b0;
        exp_adj_s  = exp;
        if (prod[2*M-1]) begin
            sig_s     = prod[2*M-1:M];
            guard_s   = prod[M-1];
            sticky_s  = |prod[M-2:0];
            exp_adj_s = exp + EXP_ONE;
        end else begin
            sig_s     = prod[2*M-2:M-1];
            guard_s   = prod[M-2];
            sticky_s  = |prod[M-3:0];
            exp_adj_s = exp;
        end

        round_up_s = guard_s & (sticky_s | sig_s[0]);
        sum_s      = {1'b0, sig_s} + {{M{1'b0}}, round_up_s};

        // A rounding carry leaves 10...0, so the upper window is already 1.0.
        if (sum_s[M]) begin
            frac_fin_s = sum_s[M-1:1];
            exp_fin_s  = exp_adj_s + EXP_ONE;
        end else begin
            frac_fin_s = sum_s[M-2:0];
            exp_fin_s  = exp_adj_s;
        end

        ovf_s = (exp_fin_s >= EXP_MAX);
        unf_s = (exp_fin_s <= EXP_ZERO);

        if (ovf_s) begin
            result = {sign, {EXP_BITS{1'b1}}, {FRAC_BITS{1'b0}}};
        end else if (unf_s) begin
            result = {sign, {(W-1){1'b0}}};
        end else begin
            result = {sign, exp_fin_s[EXP_BITS-1:0], frac_fin_s};
        end
    end

`ifdef FP_FLAGS_EN
    assign overflow  = ovf_s;
    assign underflow = unf_s;
    assign inexact   = guard_s | sticky_s | ovf_s | unf_s;
`endif

endmodule

// File: rtl/fp_mult_seq.sv
// Sequential shift-add floating-point multiplier with valid/ready handshakes.
// Optional macro FP_FLAGS_EN adds the {invalid,overflow,underflow,inexact} flags port.
module fp_mult_seq
    import fp_mult_seq_pkg::*;
#(
    parameter int EXP_BITS  = 8,
    parameter int FRAC_BITS = 23,
    localparam int W    = 1 + EXP_BITS + FRAC_BITS,
    localparam int BIAS = (2 ** (EXP_BITS - 1)) - 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result
`ifdef FP_FLAGS_EN
    ,
    output logic [3:0]   flags
`endif
);

    localparam int M  = FRAC_BITS + 1;
    localparam int EW = EXP_BITS + 2;
    localparam int CW = $clog2(M);
    localparam logic signed [EW-1:0] BIAS_S = EW'(BIAS);
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_BITS{1'b1}}, 1'b1, {(FRAC_BITS-1){1'b0}}};

    fsm_state_e             state_r;
    fsm_state_e             state_next_s;
    logic                   accept_s;
    logic                   in_ready_s;

    logic [W-1:0]           a_r;
    logic [W-1:0]           b_r;
    logic [2*M-1:0]         acc_r;
    logic [CW-1:0]          cnt_r;
    logic                   sign_r;
    logic signed [EW-1:0]   exp_r;
    logic [W-1:0]           result_r;
    logic                   out_valid_r;

    logic                   a_sign_s, b_sign_s;
    logic [EXP_BITS-1:0]    a_exp_s, b_exp_s;
    logic [FRAC_BITS-1:0]   a_frac_s, b_frac_s;
    logic [M-1:0]           a_sig_s, b_sig_s;
    logic                   a_nan_s, b_nan_s, a_inf_s, b_inf_s, a_zero_s, b_zero_s;
    logic                   special_s;
    logic [W-1:0]           spec_res_s;
    logic signed [EW-1:0]   exp_sum_s;
    logic [W-1:0]           rnd_result_s;

    assign a_sign_s = a_r[W-1];
    assign b_sign_s = b_r[W-1];
    assign a_exp_s  = a_r[W-2:FRAC_BITS];
    assign b_exp_s  = b_r[W-2:FRAC_BITS];
    assign a_frac_s = a_r[FRAC_BITS-1:0];
    assign b_frac_s = b_r[FRAC_BITS-1:0];
    assign a_sig_s  = {1'b1, a_frac_s};
    assign b_sig_s  = {1'b1, b_frac_s};

    // Denormals share the all-zero exponent with zero and are flushed alike.
    assign a_nan_s  = (&a_exp_s) & (|a_frac_s);
    assign b_nan_s  = (&b_exp_s) & (|b_frac_s);
    assign a_inf_s  = (&a_exp_s) & ~(|a_frac_s);
    assign b_inf_s  = (&b_exp_s) & ~(|b_frac_s);
    assign a_zero_s = ~(|a_exp_s);
    assign b_zero_s = ~(|b_exp_s);
    assign special_s = a_nan_s | b_nan_s | a_inf_s | b_inf_s | a_zero_s | b_zero_s;

    assign exp_sum_s = $signed({2'b00, a_exp_s}) + $signed({2'b00, b_exp_s}) - BIAS_S;

    // Special-operand result in priority order: NaN, inf*zero, inf, zero.
    always_comb begin
        spec_res_s = '0;
        if (a_nan_s || b_nan_s) begin
            spec_res_s = QNAN;
        end else if ((a_inf_s && b_zero_s) || (b_inf_s && a_zero_s)) begin
            spec_res_s = QNAN;
        end else if (a_inf_s || b_inf_s) begin
            spec_res_s = {a_sign_s ^ b_sign_s, {EXP_BITS{1'b1}}, {FRAC_BITS{1'b0}}};
        end else if (a_zero_s || b_zero_s) begin
            spec_res_s = {a_sign_s ^ b_sign_s, {(W-1){1'b0}}};
        end else begin
            spec_res_s = '0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:    state_next_s = in_valid ? UNPACK : IDLE;
            UNPACK:  state_next_s = special_s ? DONE : MUL;
            MUL:     state_next_s = (cnt_r == CW'(M - 1)) ? NORM : MUL;
            NORM:    state_next_s = DONE;
            DONE:    state_next_s = out_ready ? IDLE : DONE;
            default: state_next_s = IDLE;
        endcase
    end

    // FSM outputs: only the idle state accepts operands.
    always_comb begin
        in_ready_s = 1'b0;
        accept_s   = 1'b0;
        if (state_r == IDLE) begin
            in_ready_s = 1'b1;
            accept_s   = in_valid;
        end else begin
            in_ready_s = 1'b0;
            accept_s   = 1'b0;
        end
    end

    // Operand capture, shift-add multiply and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r         <= '0;
            b_r         <= '0;
            acc_r       <= '0;
            cnt_r       <= '0;
            sign_r      <= 1'b0;
            exp_r       <= '0;
            result_r    <= '0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        a_r <= a;
                        b_r <= b;
                    end
                end
                UNPACK: begin
                    sign_r <= a_sign_s ^ b_sign_s;
                    exp_r  <= exp_sum_s;
                    acc_r  <= '0;
                    cnt_r  <= '0;
                    if (special_s) begin
                        result_r <= spec_res_s;
                    end
                end
                MUL: begin
                    if (b_sig_s[cnt_r]) begin
                        acc_r <= acc_r + ({{M{1'b0}}, a_sig_s} << cnt_r);
                    end
                    cnt_r <= cnt_r + CW'(1);
                end
                NORM: begin
                    result_r <= rnd_result_s;
                end
                DONE: begin
                    result_r <= result_r;
                end
                default: begin
                    result_r <= result_r;
                end
            endcase
            out_valid_r <= (state_next_s == DONE);
        end
    end

`ifdef FP_FLAGS_EN
    logic [3:0] flags_r;
    logic       invalid_s;
    logic       rnd_ovf_s, rnd_unf_s, rnd_inx_s;

    assign invalid_s = ~(a_nan_s | b_nan_s) & ((a_inf_s & b_zero_s) | (b_inf_s & a_zero_s));

    fp_round_norm #(
        .EXP_BITS  (EXP_BITS),
        .FRAC_BITS (FRAC_BITS)
    ) u_round_norm (
        .prod      (acc_r),
        .sign      (sign_r),
        .exp       (exp_r),
        .result    (rnd_result_s),
        .overflow  (rnd_ovf_s),
        .underflow (rnd_unf_s),
        .inexact   (rnd_inx_s)
    );

    // Exception flags: cleared on acceptance, set in UNPACK or NORM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_r <= 4'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        flags_r <= 4'd0;
                    end
                end
                UNPACK: begin
                    if (special_s) begin
                        flags_r[FLG_INVALID] <= invalid_s;
                    end
                end
                NORM: begin
                    flags_r[FLG_OVERFLOW]  <= rnd_ovf_s;
                    flags_r[FLG_UNDERFLOW] <= rnd_unf_s;
                    flags_r[FLG_INEXACT]   <= rnd_inx_s;
                end
                default: begin
                    flags_r <= flags_r;
                end
            endcase
        end
    end

    assign flags = flags_r;
`else
    fp_round_norm #(
        .EXP_BITS  (EXP_BITS),
        .FRAC_BITS (FRAC_BITS)
    ) u_round_norm (
        .prod      (acc_r),
        .sign      (sign_r),
        .exp       (exp_r),
        .result    (rnd_result_s)
    );
`endif

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign result    = result_r;

endmodule

// File: tb/tb_fp_mult_seq.sv
// Scoreboard bench for fp_mult_seq (binary32): directed and random operands
// checked against an integer-arithmetic reference of the multiply rules.
`timescale 1ns/1ps
module tb_fp_mult_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] result;
`ifdef FP_FLAGS_EN
    logic [3:0]  flags;
`endif

    fp_mult_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
`ifdef FP_FLAGS_EN
        ,
        .flags     (flags)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flg;
        int          lat;
        int          acc_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    bit   hold_ready = 1'b0;
    bit   rand_ready = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Reference: flags = {invalid, overflow, underflow, inexact}.
    function automatic void ref_mul(input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] r, output logic [3:0] f, output int lat);
        int ex_a, ex_b, ex, sh;
        logic s;
        bit nan_x, nan_y, inf_x, inf_y, z_x, z_y;
        longint unsigned ma, mb, p, q, rem, half;
        ex_a  = int'(x[30:23]);
        ex_b  = int'(y[30:23]);
        nan_x = (ex_a == 255) && (x[22:0] != 23'd0);
        nan_y = (ex_b == 255) && (y[22:0] != 23'd0);
        inf_x = (ex_a == 255) && (x[22:0] == 23'd0);
        inf_y = (ex_b == 255) && (y[22:0] == 23'd0);
        z_x   = (ex_a == 0);
        z_y   = (ex_b == 0);
        s     = x[31] ^ y[31];
        f     = 4'b0000;
        lat   = 1;
        if (nan_x || nan_y) begin
            r = 32'h7FC00000;
        end else if ((inf_x && z_y) || (inf_y && z_x)) begin
            r = 32'h7FC00000;
            f = 4'b1000;
        end else if (inf_x || inf_y) begin
            r = {s, 8'hFF, 23'd0};
        end else if (z_x || z_y) begin
            r = {s, 31'd0};
        end else begin
            lat  = 26;
            ma   = 64'h800000 | 64'(x[22:0]);
            mb   = 64'h800000 | 64'(y[22:0]);
            p    = ma * mb;
            ex   = ex_a + ex_b - 127;
            if (p >= (64'd1 << 47)) begin
                sh = 24;
                ex = ex + 1;
            end else begin
                sh = 23;
            end
            q    = p >> sh;
            rem  = p - (q << sh);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 64'd1;
            if (q == (64'd1 << 24)) begin
                q  = 64'd1 << 23;
                ex = ex + 1;
            end
            if (ex >= 255) begin
                r = {s, 8'hFF, 23'd0};
                f = 4'b0101;
            end else if (ex <= 0) begin
                r = {s, 31'd0};
                f = 4'b0011;
            end else begin
                logic [63:0] qv;
                qv = q;
                r  = {s, 8'(ex), qv[22:0]};
                f  = (rem != 64'd0) ? 4'b0001 : 4'b0000;
            end
        end
    endfunction

    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input bit track);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        a = ia;
        b = ib;
        in_valid = 1'b1;
        while (!in_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: in_ready stayed %b, required 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (track) begin
            ref_mul(ia, ib, e.res, e.flg, e.lat);
            e.a = ia;
            e.b = ib;
            e.acc_cyc = cyc;
            sb_q.push_back(e);
        end
    endtask

    task automatic monitor();
        bit   seen;
        int   seen_cyc;
        exp_t e;
        seen = 1'b0;
        seen_cyc = 0;
        forever begin
            @(negedge clk);
            if (out_valid && !seen) begin
                seen = 1'b1;
                seen_cyc = cyc;
            end
            if (!out_valid) seen = 1'b0;
            if (out_valid && out_ready) begin
                seen = 1'b0;
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got result %h with no pending operation", result);
                end else begin
                    e = sb_q.pop_front();
                    chk($sformatf("result a=%h b=%h", e.a, e.b), result, e.res);
`ifdef FP_FLAGS_EN
                    chk($sformatf("flags a=%h b=%h", e.a, e.b), 32'(flags), 32'(e.flg));
`endif
                    chk($sformatf("latency a=%h b=%h", e.a, e.b), 32'(seen_cyc - e.acc_cyc), 32'(e.lat));
                end
            end
        end
    endtask

    task automatic ready_drv();
        forever begin
            @(posedge clk);
            #2;
            if (hold_ready)      out_ready = 1'b0;
            else if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
            else                 out_ready = 1'b1;
        end
    endtask

    function automatic logic [31:0] rand_operand();
        logic [7:0]  e;
        logic [22:0] fr;
        int          k;
        k  = int'($urandom_range(0, 15));
        case (k)
            0:       e = 8'd0;
            1:       e = 8'hFF;
            2:       e = 8'($urandom_range(1, 6));
            3:       e = 8'($urandom_range(248, 254));
            default: e = 8'($urandom_range(96, 158));
        endcase
        fr = 23'($urandom());
        if ($urandom_range(0, 7) == 0) fr = 23'd0;
        return {1'($urandom_range(0, 1)), e, fr};
    endfunction

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    logic [31:0] dir_a [8] = '{32'h40400000, 32'h7F800000, 32'h7FC12345, 32'h7F7FFFFF,
                               32'h00800000, 32'h3F800001, 32'hBFC00000, 32'h00012345};
    logic [31:0] dir_b [8] = '{32'h40200000, 32'h00000000, 32'h00000000, 32'h40000000,
                               32'h3F000000, 32'h3F800001, 32'h40000000, 32'hFF800000};

    initial begin
        int n;
        fork
            monitor();
            ready_drv();
        join_none

        repeat (3) @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_result", result, 32'd0);
`ifdef FP_FLAGS_EN
        chk("reset_flags", 32'(flags), 32'd0);
`endif
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) issue(dir_a[i], dir_b[i], 1'b1);
        drain();

        // Back-pressure: result held, busy inputs ignored.
        hold_ready = 1'b1;
        issue(32'h40400000, 32'h40200000, 1'b1);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("hold_out_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a = 32'h3F800000;
            b = 32'h3F800000;
            in_valid = 1'b1;
            chk("hold_result", result, 32'h40F00000);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        hold_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("release_in_ready", 32'(in_ready), 32'd1);
        chk("release_out_valid", 32'(out_valid), 32'd0);
        issue(32'hC0A00000, 32'h3E800000, 1'b1);
        drain();

        // Reset in the middle of the multiply aborts it.
        issue(32'h40400000, 32'h40200000, 1'b0);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        issue(32'h40400000, 32'h40200000, 1'b1);
        drain();

        rand_ready = 1'b1;
        for (int i = 0; i < 80; i++) issue(rand_operand(), rand_operand(), 1'b1);
        drain();
        repeat (40) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
